// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with
// quotient/remainder and a one-cycle valid pulse on completion.
module divider #(
  parameter int DATA_WIDTH_1 = 8,
  parameter int DATA_WIDTH_2 = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [DATA_WIDTH_1-1:0] data1_i,
  input  logic [DATA_WIDTH_2-1:0] data2_i,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic [DATA_WIDTH_1-1:0] quotient_o,
  output logic [DATA_WIDTH_2-1:0] remainder_o,
  output logic                    div_by_zero_o
);

  localparam int CW = $clog2(DATA_WIDTH_1 + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH_1-1:0] dvd_q;    // dividend shifts out, quotient shifts in
  logic [DATA_WIDTH_2-1:0] dvs_q;
  logic [DATA_WIDTH_2-1:0] part_q;   // always < divisor between iterations
  logic [CW-1:0]           cnt_q;

  logic [DATA_WIDTH_2:0]   shifted, diff;
  logic [DATA_WIDTH_2-1:0] part_nxt;
  logic [DATA_WIDTH_1-1:0] dvd_nxt;
  logic                    ge, last, accept, dbz_req;

  // The shifted partial is one bit wider than the divisor; the borrow out of
  // the subtraction doubles as the compare result.
  always_comb begin
    shifted  = {part_q, dvd_q[DATA_WIDTH_1-1]};
    diff     = shifted - {1'b0, dvs_q};
    ge       = ~diff[DATA_WIDTH_2];
    part_nxt = ge ? diff[DATA_WIDTH_2-1:0] : shifted[DATA_WIDTH_2-1:0];
    dvd_nxt  = {dvd_q[DATA_WIDTH_1-2:0], ge};
    last     = (cnt_q == CW'(1));
    accept   = (state == IDLE) && start_i && (data2_i != '0);
    dbz_req  = (state == IDLE) && start_i && (data2_i == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q         <= '0;
      dvs_q         <= '0;
      part_q        <= '0;
      cnt_q         <= '0;
      valid_o       <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        dvd_q  <= data1_i;
        dvs_q  <= data2_i;
        part_q <= '0;
        cnt_q  <= CW'(DATA_WIDTH_1);
      end else if (state == CALC) begin
        dvd_q  <= dvd_nxt;
        part_q <= part_nxt;
        cnt_q  <= cnt_q - CW'(1);
        if (last) begin
          quotient_o    <= dvd_nxt;
          remainder_o   <= part_nxt;
          div_by_zero_o <= 1'b0;
          valid_o       <= 1'b1;
        end
      end
      if (dbz_req) begin
        quotient_o    <= '1;
        remainder_o   <= '0;
        div_by_zero_o <= 1'b1;
        valid_o       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed + randomised bench for divider: 8/8 and 16/4 instances, scoreboard queues.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0;
  logic [3:0]  b16 = '0;
  logic        busy8, valid8, dbz8, busy16, valid16, dbz16;
  logic [7:0]  q8, r8;
  logic [15:0] q16;
  logic [3:0]  r16;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;
  exp_t sb8[$], sb16[$];

  divider #(.DATA_WIDTH_1(8), .DATA_WIDTH_2(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .data1_i(a8), .data2_i(b8),
    .busy_o(busy8), .valid_o(valid8), .quotient_o(q8), .remainder_o(r8),
    .div_by_zero_o(dbz8));

  divider #(.DATA_WIDTH_1(16), .DATA_WIDTH_2(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(start16), .data1_i(a16), .data2_i(b16),
    .busy_o(busy16), .valid_o(valid16), .quotient_o(q16), .remainder_o(r16),
    .div_by_zero_o(dbz16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse from a point just after an edge; returns just after the accepting edge.
  task automatic start_op(input bit wide, input int a, input int b, input bit push);
    exp_t e;
    if (b == 0) begin
      e.q = wide ? 32'hFFFF : 32'hFF; e.r = 0; e.dbz = 1'b1; e.lat = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = wide ? 16 : 8;
    end
    if (wide) begin start16 = 1'b1; a16 = a[15:0]; b16 = b[3:0]; end
    else      begin start8  = 1'b1; a8  = a[7:0];  b8  = b[7:0]; end
    if (push) begin
      if (wide) sb16.push_back(e);
      else      sb8.push_back(e);
    end
    tick();
    acc_cyc = cyc;
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic sample(input bit wide, output logic v, output logic bz, output logic [31:0] q,
                        output logic [31:0] r, output logic z);
    if (wide) begin v = valid16; bz = busy16; q = 32'(q16); r = 32'(r16); z = dbz16; end
    else      begin v = valid8;  bz = busy8;  q = 32'(q8);  r = 32'(r8);  z = dbz8;  end
  endtask

  // Waits (bounded) for valid, then pops the scoreboard and compares; leaves time in the valid cycle.
  task automatic wait_result(input bit wide, input string tag, input int exp_busy);
    int busy_n = 0, guard = 0;
    logic v, bz, z;
    logic [31:0] q, r;
    exp_t e;
    sample(wide, v, bz, q, r, z);
    while (!v && guard < 64) begin
      if (bz) busy_n++;
      tick();
      guard++;
      sample(wide, v, bz, q, r, z);
    end
    check({tag, "_valid_seen"}, 32'(v), 32'd1);
    if (v) begin
      if ((wide ? sb16.size() : sb8.size()) == 0) begin
        check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = wide ? sb16.pop_front() : sb8.pop_front();
        check({tag, "_q"}, q, e.q);
        check({tag, "_r"}, r, e.r);
        check({tag, "_dbz"}, 32'(z), 32'(e.dbz));
        check({tag, "_lat"}, 32'(cyc - acc_cyc), 32'(e.lat));
        check({tag, "_busy_done"}, 32'(bz), 32'd0);
        if (exp_busy >= 0) check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      end
    end
  endtask

  initial begin
    int ta[4], tb[4];
    bit seen;
    ta = '{255, 5, 255, 0};
    tb = '{255, 9, 1, 3};

    #23 rst_n = 1'b1;
    tick();
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_valid", 32'(valid8), 32'd0);
    check("rst_q", 32'(q8), 32'd0);
    check("rst_r", 32'(r8), 32'd0);
    check("rst_dbz", 32'(dbz8), 32'd0);

    // Basic 200/7
    start_op(1'b0, 200, 7, 1'b1);
    wait_result(1'b0, "basic", 8);
    tick();
    check("basic_valid_one_cycle", 32'(valid8), 32'd0);
    check("basic_q_hold", 32'(q8), 32'd28);

    for (int i = 0; i < 4; i++) begin
      start_op(1'b0, ta[i], tb[i], 1'b1);
      wait_result(1'b0, $sformatf("bound%0d", i), 8);
    end

    // Divide by zero: immediate result, never busy
    start_op(1'b0, 77, 0, 1'b1);
    wait_result(1'b0, "dbz", 0);
    tick();
    check("dbz_hold", 32'(dbz8), 32'd1);

    // Start while busy is ignored, then back-to-back restart in the valid cycle
    start_op(1'b0, 100, 3, 1'b1);
    tick();
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd2;
    tick();
    start8 = 1'b0; a8 = 8'hAA; b8 = 8'd0;
    check("ignore_busy", 32'(busy8), 32'd1);
    wait_result(1'b0, "ignore", -1);
    start_op(1'b0, 9, 2, 1'b1);
    wait_result(1'b0, "b2b", 8);

    // Reset mid-operation
    start_op(1'b0, 200, 7, 1'b0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_valid", 32'(valid8), 32'd0);
    check("abort_q", 32'(q8), 32'd0);
    check("abort_r", 32'(r8), 32'd0);
    check("abort_dbz", 32'(dbz8), 32'd0);
    #10 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid8) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    start_op(1'b0, 50, 6, 1'b1);
    wait_result(1'b0, "after_rst", 8);

    // 16/4 instance
    start_op(1'b1, 65535, 15, 1'b1);
    wait_result(1'b1, "w16_max", 16);
    for (int i = 0; i < 10; i++) begin
      int a, b;
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 15));
      start_op(1'b1, a, b, 1'b1);
      wait_result(1'b1, $sformatf("w16_rand%0d", i), -1);
    end
    for (int i = 0; i < 6; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      start_op(1'b0, a, b, 1'b1);
      wait_result(1'b0, $sformatf("w8_rand%0d", i), 8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
